// File: rtl/ahb_pkg.sv
// Shared AHB bus types: widths, transfer/response encodings and the master/slave port bundles.
package ahb_pkg;
  localparam int AHB_AW  = 32;
  localparam int AHB_DW  = 32;
  localparam int AHB_PW  = 2;
  localparam int NUM_MST = 4;
  localparam int NUM_SLV = 7;
  localparam logic [2:0] DEF_SLV = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} hresp_t;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} def_state_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000, HBURST_INCR  = 3'b001,
                         HBURST_WRAP4  = 3'b010, HBURST_INCR4 = 3'b011,
                         HBURST_WRAP8  = 3'b100, HBURST_INCR8 = 3'b101,
                         HBURST_WRAP16 = 3'b110, HBURST_INCR16 = 3'b111;
  localparam logic [2:0] HSIZE_BYTE = 3'b000, HSIZE_HALF = 3'b001, HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic [AHB_AW-1:0] haddr;
    htrans_t           htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [AHB_DW-1:0] hwdata;
  } mas_in_t;

  typedef struct packed {
    logic              hready;
    hresp_t            hresp;
    logic [AHB_DW-1:0] hrdata;
  } mas_out_t;

  typedef struct packed {
    logic              hsel;
    logic [AHB_AW-1:0] haddr;
    htrans_t           htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [AHB_DW-1:0] hwdata;
    logic              hready;
  } slv_in_t;

  typedef struct packed {
    logic [AHB_DW-1:0] hrdata;
    logic              hreadyout;
    hresp_t            hresp;
  } slv_out_t;

  // Top address nibble 0..6 maps to slave_1..slave_7, everything above to the default slave.
  function automatic logic [2:0] addr_decode(input logic [3:0] nib);
    return (nib < 4'd7) ? nib[2:0] : DEF_SLV;
  endfunction
endpackage

// File: rtl/ahb_arbiter.sv
// Four-way priority arbiter: highest priority wins, lowest index on ties, owner parks when idle.
module ahb_arbiter import ahb_pkg::*; #(
  parameter int PW = AHB_PW
) (
  input  logic                       hclk,
  input  logic                       hreset_n,
  input  logic [NUM_MST-1:0]         req,
  input  logic [NUM_MST-1:0][PW-1:0] prio,
  input  logic                       owner_seq,
  input  logic                       bus_ready,
  output logic [1:0]                 grant,
  output logic [1:0]                 owner
);
  logic [1:0]    win;
  logic [PW-1:0] best;
  logic          any_req;

  always_comb begin
    win     = owner;
    best    = '0;
    any_req = 1'b0;
    // Strict '>' keeps the earliest index among equal priorities.
    for (int i = 0; i < NUM_MST; i++) begin
      if (req[i] && (!any_req || prio[i] > best)) begin
        win     = 2'(i);
        best    = prio[i];
        any_req = 1'b1;
      end
    end
  end

  // Ownership only moves on an accepted, non-SEQ address phase.
  assign grant = (bus_ready && !owner_seq && any_req) ? win : owner;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) owner <= '0;
    else           owner <= grant;
  end
endmodule

// File: rtl/ahb_bus.sv
// Shared-bus AHB interconnect: 4 masters, 7 slaves plus an internal default slave.
module ahb_bus import ahb_pkg::*; #(
  parameter int AW = AHB_AW,
  parameter int DW = AHB_DW,
  parameter int PW = AHB_PW
) (
  input  logic          hclk,
  input  logic          hreset_n,
  input  mas_in_t       master_1_in,
  input  mas_in_t       master_2_in,
  input  mas_in_t       master_3_in,
  input  mas_in_t       kemee_in,
  input  logic [PW-1:0] hprior_master_1,
  input  logic [PW-1:0] hprior_master_2,
  input  logic [PW-1:0] hprior_master_3,
  input  logic [PW-1:0] hprior_kemee,
  output mas_out_t      master_1_out,
  output mas_out_t      master_2_out,
  output mas_out_t      master_3_out,
  output mas_out_t      kemee_out,
  output slv_in_t       slave_1_in,
  output slv_in_t       slave_2_in,
  output slv_in_t       slave_3_in,
  output slv_in_t       slave_4_in,
  output slv_in_t       slave_5_in,
  output slv_in_t       slave_6_in,
  output slv_in_t       slave_7_in,
  input  slv_out_t      slave_1_out,
  input  slv_out_t      slave_2_out,
  input  slv_out_t      slave_3_out,
  input  slv_out_t      slave_4_out,
  input  slv_out_t      slave_5_out,
  input  slv_out_t      slave_6_out,
  input  slv_out_t      slave_7_out
);
  mas_in_t  [NUM_MST-1:0]         m_in;
  mas_out_t [NUM_MST-1:0]         m_out;
  slv_in_t  [NUM_SLV-1:0]         s_in;
  slv_out_t [NUM_SLV-1:0]         s_out;
  logic     [NUM_MST-1:0][PW-1:0] prio;
  logic     [NUM_MST-1:0]         req;

  assign m_in  = {kemee_in, master_3_in, master_2_in, master_1_in};
  assign prio  = {hprior_kemee, hprior_master_3, hprior_master_2, hprior_master_1};
  assign s_out = {slave_7_out, slave_6_out, slave_5_out, slave_4_out,
                  slave_3_out, slave_2_out, slave_1_out};
  assign {kemee_out, master_3_out, master_2_out, master_1_out} = m_out;
  assign {slave_7_in, slave_6_in, slave_5_in, slave_4_in,
          slave_3_in, slave_2_in, slave_1_in} = s_in;

  logic [1:0] grant, owner, dp_master;
  logic [2:0] sel, dp_slave;
  logic       dp_valid, active, bus_ready, owner_seq;

  always_comb begin
    for (int m = 0; m < NUM_MST; m++) req[m] = m_in[m].htrans[1] & hreset_n;
  end

  assign owner_seq = (m_in[owner].htrans == SEQ);
  assign active    = m_in[grant].htrans[1] & hreset_n;
  assign sel       = addr_decode(m_in[grant].haddr[AW-1 -: 4]);

  ahb_arbiter #(.PW(PW)) u_arb (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .req       (req),
    .prio      (prio),
    .owner_seq (owner_seq),
    .bus_ready (bus_ready),
    .grant     (grant),
    .owner     (owner)
  );

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      dp_valid  <= 1'b0;
      dp_master <= '0;
      dp_slave  <= '0;
    end else if (bus_ready) begin
      dp_valid  <= active;
      dp_master <= grant;
      dp_slave  <= sel;
    end
  end

  // Default slave: active transfers get a two-cycle ERROR, first cycle stalled.
  def_state_t ds_q, ds_d;
  logic       def_ready;
  hresp_t     def_resp;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) ds_q <= DS_IDLE;
    else           ds_q <= ds_d;
  end

  always_comb begin
    ds_d = ds_q;
    if (bus_ready)             ds_d = (active && sel == DEF_SLV) ? DS_ERR1 : DS_IDLE;
    else if (ds_q == DS_ERR1)  ds_d = DS_ERR2;
  end

  assign def_ready = (ds_q != DS_ERR1);
  assign def_resp  = (ds_q == DS_IDLE) ? OKAY : ERROR;

  logic   [7:0]         rdy_vec;
  hresp_t [7:0]         resp_vec;
  logic   [7:0][DW-1:0] rdata_vec;

  always_comb begin
    rdy_vec   = '1;
    resp_vec  = {8{OKAY}};
    rdata_vec = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      rdy_vec[s]   = s_out[s].hreadyout;
      resp_vec[s]  = s_out[s].hresp;
      rdata_vec[s] = s_out[s].hrdata;
    end
    rdy_vec[DEF_SLV]  = def_ready;
    resp_vec[DEF_SLV] = def_resp;
  end

  assign bus_ready = dp_valid ? rdy_vec[dp_slave] : 1'b1;

  always_comb begin
    s_in = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      s_in[s].hsel   = hreset_n & (sel == 3'(s));
      s_in[s].haddr  = m_in[grant].haddr;
      s_in[s].htrans = hreset_n ? m_in[grant].htrans : IDLE;
      s_in[s].hwrite = m_in[grant].hwrite;
      s_in[s].hsize  = m_in[grant].hsize;
      s_in[s].hburst = m_in[grant].hburst;
      s_in[s].hprot  = m_in[grant].hprot;
      s_in[s].hwdata = m_in[dp_master].hwdata;
      s_in[s].hready = bus_ready;
    end
  end

  // Owners follow the bus; requesters still waiting for a grant are held off.
  always_comb begin
    m_out = '0;
    for (int m = 0; m < NUM_MST; m++) begin
      m_out[m].hready = 1'b1;
      m_out[m].hresp  = OKAY;
      m_out[m].hrdata = '0;
      if (hreset_n) begin
        if ((dp_valid && dp_master == 2'(m)) || grant == 2'(m)) m_out[m].hready = bus_ready;
        else if (req[m])                                        m_out[m].hready = 1'b0;
        if (dp_valid && dp_master == 2'(m)) begin
          m_out[m].hresp  = resp_vec[dp_slave];
          m_out[m].hrdata = rdata_vec[dp_slave];
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_bus.sv
// Self-checking bench for ahb_bus: directed cycle sequences with a scoreboard for data-phase results.
module tb_ahb_bus;
  import ahb_pkg::*;

  logic       hclk, hreset_n;
  mas_in_t    mi [4];
  mas_out_t   mo [4];
  slv_in_t    si [7];
  slv_out_t   so [7];
  logic [1:0] pr [4];
  logic [6:0] stall;
  logic [6:0] hsel_v;
  logic [3:0] hrdy_v;
  int         vec, miss;
  logic [31:0] sb_q [$];

  ahb_bus dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .master_1_in(mi[0]), .master_2_in(mi[1]), .master_3_in(mi[2]), .kemee_in(mi[3]),
    .hprior_master_1(pr[0]), .hprior_master_2(pr[1]), .hprior_master_3(pr[2]), .hprior_kemee(pr[3]),
    .master_1_out(mo[0]), .master_2_out(mo[1]), .master_3_out(mo[2]), .kemee_out(mo[3]),
    .slave_1_in(si[0]), .slave_2_in(si[1]), .slave_3_in(si[2]), .slave_4_in(si[3]),
    .slave_5_in(si[4]), .slave_6_in(si[5]), .slave_7_in(si[6]),
    .slave_1_out(so[0]), .slave_2_out(so[1]), .slave_3_out(so[2]), .slave_4_out(so[3]),
    .slave_5_out(so[4]), .slave_6_out(so[5]), .slave_7_out(so[6])
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Slave models: fixed read data per slave, stallable ready.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      so[i].hrdata    = 32'hD000_0000 + 32'(i);
      so[i].hreadyout = ~stall[i];
      so[i].hresp     = OKAY;
    end
  end

  always_comb begin
    hsel_v = '0;
    hrdy_v = '0;
    for (int i = 0; i < 7; i++) hsel_v[i] = si[i].hsel;
    for (int i = 0; i < 4; i++) hrdy_v[i] = mo[i].hready;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    else                  chk(tag, 64'(got), 64'(sb_q.pop_front()));
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drv(input int m, input htrans_t t, input logic [31:0] a, input logic w,
                     input logic [31:0] wd, input logic [2:0] b);
    mi[m].htrans = t;
    mi[m].haddr  = a;
    mi[m].hwrite = w;
    mi[m].hwdata = wd;
    mi[m].hburst = b;
    mi[m].hsize  = HSIZE_WORD;
    mi[m].hprot  = 4'h3;
  endtask

  task automatic idle_all();
    for (int m = 0; m < 4; m++) mi[m].htrans = IDLE;
  endtask

  initial begin
    vec = 0; miss = 0;
    stall = '0;
    for (int m = 0; m < 4; m++) begin mi[m] = '0; pr[m] = '0; end
    hreset_n = 1'b0;

    // Reset: requests present but must be masked
    drv(0, NONSEQ, 32'h0000_0000, 1'b0, 32'h0, HBURST_SINGLE);
    drv(1, NONSEQ, 32'h2000_0000, 1'b0, 32'h0, HBURST_SINGLE);
    tick(); tick(); #1;
    chk("rst_hsel", hsel_v, 7'h00);
    chk("rst_htrans", si[0].htrans, IDLE);
    chk("rst_hready", hrdy_v, 4'hF);
    chk("rst_hresp", mo[1].hresp, OKAY);
    chk("rst_bus_ready", si[0].hready, 1'b1);
    idle_all();
    tick(); hreset_n = 1'b1;
    tick();

    // master_2 single write to slave_3
    tick(); drv(1, NONSEQ, 32'h2000_0010, 1'b1, 32'h0, HBURST_SINGLE); #1;
    chk("wr_hsel", hsel_v, 7'b0000100);
    chk("wr_haddr", si[2].haddr, 32'h2000_0010);
    chk("wr_m2_ready", mo[1].hready, 1'b1);
    sb_push(32'hA5A5_A5A5);
    tick(); mi[1].htrans = IDLE; mi[1].hwdata = 32'hA5A5_A5A5; #1;
    sb_pop("wr_hwdata", si[2].hwdata);
    chk("wr_m1_rdata", mo[0].hrdata, 32'h0);

    // Equal priority, all four request: master_1, then master_2
    tick();
    drv(0, NONSEQ, 32'h0000_0000, 1'b0, 32'h0, HBURST_SINGLE);
    drv(1, NONSEQ, 32'h1000_0000, 1'b0, 32'h0, HBURST_SINGLE);
    drv(2, NONSEQ, 32'h2000_0000, 1'b0, 32'h0, HBURST_SINGLE);
    drv(3, NONSEQ, 32'h3000_0000, 1'b0, 32'h0, HBURST_SINGLE);
    #1;
    chk("tie_hsel", hsel_v, 7'b0000001);
    chk("tie_hready", hrdy_v, 4'b0001);
    sb_push(32'hD000_0000);
    tick(); mi[0].htrans = IDLE; #1;
    chk("tie2_hsel", hsel_v, 7'b0000010);
    chk("tie2_hready", hrdy_v, 4'b0011);
    sb_pop("tie_m1_rdata", mo[0].hrdata);
    sb_push(32'hD000_0001);
    tick(); idle_all(); #1;
    sb_pop("tie_m2_rdata", mo[1].hrdata);

    // master_1 prio 1 vs kemee prio 3
    tick();
    pr[0] = 2'd1; pr[3] = 2'd3;
    drv(0, NONSEQ, 32'h0000_0100, 1'b0, 32'h0, HBURST_SINGLE);
    drv(3, NONSEQ, 32'h4000_0000, 1'b0, 32'h0, HBURST_SINGLE);
    #1;
    chk("pri_hsel", hsel_v, 7'b0010000);
    chk("pri_m1_ready", mo[0].hready, 1'b0);
    chk("pri_k_ready", mo[3].hready, 1'b1);
    sb_push(32'hD000_0004);
    tick(); mi[3].haddr = 32'h4000_0004; #1;
    sb_pop("pri_k_rdata0", mo[3].hrdata);
    chk("pri_m1_held", mo[0].hready, 1'b0);
    sb_push(32'hD000_0004);
    tick(); mi[3].htrans = IDLE; #1;
    sb_pop("pri_k_rdata1", mo[3].hrdata);
    chk("pri_m1_grant", mo[0].hready, 1'b1);
    chk("pri_m1_hsel", hsel_v, 7'b0000001);
    sb_push(32'hD000_0000);
    tick(); idle_all(); pr[0] = '0; pr[3] = '0; #1;
    sb_pop("pri_m1_rdata", mo[0].hrdata);

    // master_3 INCR4 burst is not preempted by master_1 at prio 3
    tick(); drv(2, NONSEQ, 32'h1000_0000, 1'b1, 32'h0, HBURST_INCR4); #1;
    chk("bst_m3_ready", mo[2].hready, 1'b1);
    chk("bst_hsel", hsel_v, 7'b0000010);
    sb_push(32'hB000_0000);
    for (int b = 1; b < 4; b++) begin
      tick();
      drv(2, SEQ, 32'h1000_0000 + 32'(4*b), 1'b1, 32'hB000_0000 + 32'(b-1), HBURST_INCR4);
      drv(0, NONSEQ, 32'h0000_0000, 1'b0, 32'h0, HBURST_SINGLE);
      pr[0] = 2'd3;
      #1;
      chk("bst_seq_hsel", hsel_v, 7'b0000010);
      chk("bst_seq_htrans", si[1].htrans, SEQ);
      chk("bst_m1_held", mo[0].hready, 1'b0);
      sb_pop("bst_hwdata", si[1].hwdata);
      sb_push(32'hB000_0000 + 32'(b));
    end
    tick(); mi[2].htrans = IDLE; mi[2].hwdata = 32'hB000_0003; #1;
    sb_pop("bst_hwdata_last", si[1].hwdata);
    chk("bst_m1_grant", mo[0].hready, 1'b1);
    chk("bst_m1_hsel", hsel_v, 7'b0000001);
    sb_push(32'hD000_0000);
    tick(); idle_all(); pr[0] = '0; #1;
    sb_pop("bst_m1_rdata", mo[0].hrdata);

    // Unmapped read -> default slave two-cycle ERROR
    tick(); drv(2, NONSEQ, 32'h9000_0000, 1'b0, 32'h0, HBURST_SINGLE); #1;
    chk("err_hsel", hsel_v, 7'h00);
    chk("err_addr_ready", mo[2].hready, 1'b1);
    sb_push(32'(ERROR));
    tick(); mi[2].htrans = IDLE; #1;
    chk("err_c1_ready", mo[2].hready, 1'b0);
    sb_pop("err_c1_resp", 32'(mo[2].hresp));
    sb_push(32'(ERROR));
    tick(); #1;
    chk("err_c2_ready", mo[2].hready, 1'b1);
    sb_pop("err_c2_resp", 32'(mo[2].hresp));
    tick(); #1;
    chk("err_after_resp", mo[2].hresp, OKAY);

    // slave_5 inserts 3 wait states on kemee's read
    tick(); drv(3, NONSEQ, 32'h4000_0000, 1'b0, 32'h0, HBURST_SINGLE); #1;
    sb_push(32'hD000_0004);
    for (int w = 0; w < 3; w++) begin
      tick();
      mi[3].htrans = IDLE; stall[4] = 1'b1;
      drv(0, NONSEQ, 32'h0000_0000, 1'b0, 32'h0, HBURST_SINGLE);
      pr[0] = 2'd3;
      #1;
      chk("ws_k_ready", mo[3].hready, 1'b0);
      chk("ws_m1_ready", mo[0].hready, 1'b0);
      chk("ws_hsel", hsel_v, 7'b0010000);
      chk("ws_bus_ready", si[4].hready, 1'b0);
    end
    tick(); stall[4] = 1'b0; #1;
    chk("ws_k_done", mo[3].hready, 1'b1);
    sb_pop("ws_k_rdata", mo[3].hrdata);
    chk("ws_m1_hsel", hsel_v, 7'b0000001);
    chk("ws_m1_grant", mo[0].hready, 1'b1);
    sb_push(32'hD000_0000);
    tick(); idle_all(); pr[0] = '0; #1;
    sb_pop("ws_m1_rdata", mo[0].hrdata);

    // Reset in the middle of a default-slave error response
    tick(); drv(3, NONSEQ, 32'h9000_0000, 1'b0, 32'h0, HBURST_SINGLE); #1;
    tick(); mi[3].htrans = IDLE; #1;
    chk("mrst_pre_ready", mo[3].hready, 1'b0);
    hreset_n = 1'b0; #1;
    chk("mrst_ready", mo[3].hready, 1'b1);
    chk("mrst_resp", mo[3].hresp, OKAY);
    chk("mrst_bus_ready", si[0].hready, 1'b1);
    chk("mrst_hsel", hsel_v, 7'h00);
    tick(); hreset_n = 1'b1; #1;
    chk("post_rst_resp", mo[3].hresp, OKAY);
    chk("post_rst_ready", mo[3].hready, 1'b1);
    chk("post_rst_owner", hsel_v, 7'b0000001);
    tick(); #1;
    chk("post_rst_resp2", mo[3].hresp, OKAY);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
